hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Parametrised hazard unit for the in-order RISC-V pipeline, placed beside the ID stage. It keeps its own scoreboard of in-flight register writes. From that scoreboard it forwards the youngest ready result to the ID operands, stalls on load-use, and flushes on branch/jump redirect. The stage count, data width and load-ready stage are all parameters.

## Interface
- `XLEN`, 32, datapath width
- `AW`, 5, register-index width
- `NSTG`, 3, tracked stages past ID (0 = EX, 1 = MEM, 2 = WB)
- `LOAD_RDY`, 1, first stage index at which load data is valid on `stg_wd`
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `id_valid` in 1: ID holds a real instruction
- `id_rs1`, `id_rs2` in AW: source indices
- `id_use_rs1`, `id_use_rs2` in 1: the source is actually read; prevents false hazards for I/U/J types
- `id_rd` in AW: destination index
- `id_we` in 1: ID instruction writes `rd`
- `id_is_load` in 1: ID instruction is a load
- `id_rd1`, `id_rd2` in XLEN: register-file read data
- `stg_wd` in NSTG*XLEN: write-back value per stage; stage k occupies `[k*XLEN +: XLEN]`
- `redirect` in 1: branch/jump taken, resolved in ID
- `final_rs1`, `final_rs2` out XLEN: operands after forwarding
- `stall` out 1: hold PC and IF/ID
- `if_id_flush`, `id_ex_flush` out 1: clear the respective pipeline register

## Operation
- Scoreboard: NSTG entries `{v, rd, ld}`; entry 0 = instruction now in EX.
- Each clock: `ent[k] <= ent[k-1]` for k ≥ 1.
- Each clock, entry 0 loads `{1, id_rd, id_is_load}` when `id_valid & id_we & (id_rd != 0) & ~stall & ~redirect`; otherwise it loads a bubble (`v = 0`).
- Match(src, k) = `ent[k].v & (ent[k].rd == src) & use_src`; `src == 0` never matches.
- Load-use: if Match with `ent[k].ld` and `k < LOAD_RDY` for either source, raise `stall`. The stall also asserts `id_ex_flush` to inject a bubble.
- Forwarding: take the lowest k with a match, i.e. the youngest writer. If that match is load-not-ready, `stall` is asserted and the operand value is don't-care. With no match, `final_rsX = id_rdX`.
- `redirect`: `if_id_flush = id_ex_flush = 1`. Redirect wins over stall: `stall` is forced to 0 when `redirect` is 1.
- Flush and stall are level outputs; the pipeline registers act on the next edge.

## Timing
- All outputs are combinational from scoreboard state plus ID inputs; scoreboard update latency is 1 cycle.
- Reset, asynchronous:
  - all `ent.v = 0`
  - `stall = 0`, flushes = 0 (absent `redirect`)
  - `final_rsX = id_rdX`
  - counters = 0
- Load-use with `LOAD_RDY = 1` gives 1 stall cycle: the load moves to entry 1 and then forwards from MEM.
- With `LOAD_RDY = L`, the stall lasts L cycles.
- An entry shifting out of stage NSTG-1 is dropped; the register file must be written by then (write-first or WB-forward covers it).
- Reset asserted mid-stall clears the scoreboard immediately; `stall` drops in the same cycle.
- With `redirect` and a load-use hazard in the same cycle, the ID instruction is discarded and not stalled.

## Configuration
- `HAZ_PERF_CNT_EN` defined:
  - adds outputs `stall_cnt` [31:0] and `flush_cnt` [31:0]
  - `stall_cnt` increments per cycle with `stall`; `flush_cnt` increments per cycle with `redirect`
  - both saturate at `32'hFFFF_FFFF` and reset to 0
- Undefined: neither the ports nor the counters exist; behaviour is otherwise identical.

## Structure
- The shared package `haz_pkg` holds:
  - the `sb_entry_t` struct `{v, rd, ld}`
  - the default constants `XLEN`, `AW`, `NSTG`, `LOAD_RDY`
- One sub-module, `haz_fwd_mux`: one instance per source, a priority search over NSTG entries that returns data and a `not_ready` flag. The scoreboard shift register stays in `hazard_ctrl`.

## Test plan
- ADD x5 in EX, then ID reads x5 with `stg_wd[0] = 0x11`: `final_rs1 = 0x11`, `stall = 0`.
- x5 written by EX (0x22) and by MEM (0x33): `final_rs1 = 0x22`, the youngest wins.
- LW x7, then ID ADD uses x7:
  - cycle 1: `stall = 1`, `id_ex_flush = 1`
  - cycle 2: `stall = 0`, `final_rs2 = stg_wd[1]`
- Writer to x0 in EX; ID reads x0 with `id_rd1 = 0`: no forward, `final_rs1 = 0`.
- `redirect = 1` with a simultaneous load-use: `stall = 0`, both flushes = 1, entry 0 is a bubble on the next cycle.
- With `HAZ_PERF_CNT_EN`: 3 load-use stalls and 2 redirects, then `rst_n` low mid-stall: counters read 3 and 2 before reset, `stall = 0` and counters = 0 immediately after.

Source files
------------

// File: rtl/haz_pkg.sv
// Shared types and default parameters for the ID-stage hazard unit.
package haz_pkg;
    localparam int XLEN     = 32;
    localparam int AW       = 5;
    localparam int NSTG     = 3;
    localparam int LOAD_RDY = 1;

    typedef struct packed {
        logic          v;
        logic [AW-1:0] rd;
        logic          ld;
    } sb_entry_t;
endpackage

// File: rtl/haz_fwd_mux.sv
// Per-source forwarding search: youngest matching in-flight writer wins,
// with a flag when that writer is a load whose data is not yet valid.
module haz_fwd_mux #(
    parameter int XLEN     = haz_pkg::XLEN,
    parameter int AW       = haz_pkg::AW,
    parameter int NSTG     = haz_pkg::NSTG,
    parameter int LOAD_RDY = haz_pkg::LOAD_RDY
) (
    input  logic [AW-1:0]              src,
    input  logic                       use_src,
    input  logic [NSTG-1:0]            ent_v,
    input  logic [NSTG-1:0][AW-1:0]    ent_rd,
    input  logic [NSTG-1:0]            ent_ld,
    input  logic [NSTG-1:0][XLEN-1:0]  stg_wd,
    input  logic [XLEN-1:0]            rf_data,
    output logic [XLEN-1:0]            data,
    output logic                       not_ready
);
    import haz_pkg::*;

    logic found;

    always_comb begin
        data      = rf_data;
        not_ready = 1'b0;
        found     = 1'b0;
        // Ascending scan with a found latch gives lowest-index (youngest) priority.
        for (int k = 0; k < NSTG; k++) begin
            if (!found && use_src && (src != '0) && ent_v[k] && (ent_rd[k] == src)) begin
                found     = 1'b1;
                data      = stg_wd[k];
                not_ready = ent_ld[k] && (k < LOAD_RDY);
            end
        end
    end
endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard unit: scoreboard of in-flight writes, forwarding, load-use
// stall and redirect flush. Optional perf counters under HAZ_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int XLEN     = haz_pkg::XLEN,
    parameter int AW       = haz_pkg::AW,
    parameter int NSTG     = haz_pkg::NSTG,
    parameter int LOAD_RDY = haz_pkg::LOAD_RDY
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [AW-1:0]        id_rs1,
    input  logic [AW-1:0]        id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [AW-1:0]        id_rd,
    input  logic                 id_we,
    input  logic                 id_is_load,
    input  logic [XLEN-1:0]      id_rd1,
    input  logic [XLEN-1:0]      id_rd2,
    input  logic [NSTG*XLEN-1:0] stg_wd,
    input  logic                 redirect,
    output logic [XLEN-1:0]      final_rs1,
    output logic [XLEN-1:0]      final_rs2,
    output logic                 stall,
    output logic                 if_id_flush,
    output logic                 id_ex_flush
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          flush_cnt
`endif
);
    import haz_pkg::*;

    logic [NSTG-1:0]           sb_v;
    logic [NSTG-1:0][AW-1:0]   sb_rd;
    logic [NSTG-1:0]           sb_ld;
    logic [NSTG-1:0][XLEN-1:0] wd;

    logic [1:0][AW-1:0]   src;
    logic [1:0]           use_src;
    logic [1:0][XLEN-1:0] rf_data;
    logic [1:0][XLEN-1:0] fwd;
    logic [1:0]           not_ready;

    logic load_use;
    logic ins;

    assign wd      = stg_wd;
    assign src     = {id_rs2, id_rs1};
    assign use_src = {id_use_rs2, id_use_rs1};
    assign rf_data = {id_rd2, id_rd1};

    for (genvar s = 0; s < 2; s++) begin : g_src
        haz_fwd_mux #(
            .XLEN(XLEN), .AW(AW), .NSTG(NSTG), .LOAD_RDY(LOAD_RDY)
        ) u_mux (
            .src       (src[s]),
            .use_src   (use_src[s]),
            .ent_v     (sb_v),
            .ent_rd    (sb_rd),
            .ent_ld    (sb_ld),
            .stg_wd    (wd),
            .rf_data   (rf_data[s]),
            .data      (fwd[s]),
            .not_ready (not_ready[s])
        );
    end

    assign final_rs1 = fwd[0];
    assign final_rs2 = fwd[1];

    // Redirect discards the ID instruction, so it overrides any load-use stall.
    assign load_use    = id_valid && (|not_ready);
    assign stall       = load_use && !redirect;
    assign if_id_flush = redirect;
    assign id_ex_flush = redirect || stall;

    assign ins = id_valid && id_we && (id_rd != '0) && !stall && !redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_v  <= '0;
            sb_rd <= '0;
            sb_ld <= '0;
        end else begin
            for (int k = NSTG-1; k > 0; k--) begin
                sb_v[k]  <= sb_v[k-1];
                sb_rd[k] <= sb_rd[k-1];
                sb_ld[k] <= sb_ld[k-1];
            end
            sb_v[0]  <= ins;
            sb_rd[0] <= ins ? id_rd : '0;
            sb_ld[0] <= ins && id_is_load;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != 32'hFFFF_FFFF))
                stall_cnt <= stall_cnt + 32'd1;
            if (redirect && (flush_cnt != 32'hFFFF_FFFF))
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table plus multi-cycle sequences.
module tb_hazard_ctrl;
    localparam logic [31:0] RD1 = 32'hAAAA_0001;
    localparam logic [31:0] RD2 = 32'hBBBB_0002;
    localparam logic [31:0] W0  = 32'h0000_0022;
    localparam logic [31:0] W1  = 32'h0000_0033;
    localparam logic [31:0] W2  = 32'h0000_0044;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_use_rs1, id_use_rs2, id_we, id_is_load, redirect;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rd1, id_rd2;
    logic [95:0] stg_wd;
    logic [31:0] final_rs1, final_rs2;
    logic        stall, if_id_flush, id_ex_flush;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .stg_wd(stg_wd), .redirect(redirect),
        .final_rs1(final_rs1), .final_rs2(final_rs2), .stall(stall),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush)
`ifdef HAZ_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Three pushes: a[0] oldest (ends in WB), a[2] youngest (ends in EX). rd 0 = bubble.
    typedef struct {
        string       name;
        logic [4:0]  p_rd [3];
        logic        p_ld [3];
        logic [4:0]  rs1, rs2;
        logic        u1, u2, redir;
        logic [31:0] e_rs1, e_rs2;
        logic        chk_data;
        logic        e_stall, e_ifid, e_idex;
    } vec_t;

    vec_t vq[$];

    function automatic void addv(string n, logic [4:0] ra, logic la, logic [4:0] rb, logic lb,
                                 logic [4:0] rc, logic lc, logic [4:0] s1, logic u1,
                                 logic [4:0] s2, logic u2, logic rdr, logic [31:0] e1,
                                 logic [31:0] e2, logic cd, logic es, logic ef, logic ex);
        vec_t v;
        v.name = n;
        v.p_rd[0] = ra; v.p_ld[0] = la;
        v.p_rd[1] = rb; v.p_ld[1] = lb;
        v.p_rd[2] = rc; v.p_ld[2] = lc;
        v.rs1 = s1; v.u1 = u1; v.rs2 = s2; v.u2 = u2; v.redir = rdr;
        v.e_rs1 = e1; v.e_rs2 = e2; v.chk_data = cd;
        v.e_stall = es; v.e_ifid = ef; v.e_idex = ex;
        vq.push_back(v);
    endfunction

    task automatic idle_id();
        id_valid = 1'b0; id_we = 1'b0; id_is_load = 1'b0; id_rd = '0;
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; redirect = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic push(input logic [4:0] rd, input logic ld);
        idle_id();
        id_valid = 1'b1; id_we = 1'b1; id_rd = rd; id_is_load = ld;
        @(posedge clk); #1;
    endtask

    task automatic set_id(input logic [4:0] s1, input logic u1, input logic [4:0] s2,
                          input logic u2, input logic [4:0] rd, input logic rdr);
        id_valid = 1'b1; id_we = 1'b1; id_is_load = 1'b0; id_rd = rd;
        id_rs1 = s1; id_use_rs1 = u1; id_rs2 = s2; id_use_rs2 = u2; redirect = rdr;
    endtask

    task automatic check_ctl(input string n, input logic es, input logic ef, input logic ex);
        check({n, ".stall"}, {31'd0, stall}, {31'd0, es});
        check({n, ".if_id_flush"}, {31'd0, if_id_flush}, {31'd0, ef});
        check({n, ".id_ex_flush"}, {31'd0, id_ex_flush}, {31'd0, ex});
    endtask

    initial begin
        id_rd1 = RD1; id_rd2 = RD2; stg_wd = {W2, W1, W0};
        idle_id();
        rst_n = 1'b0;
        #2;
        // Reset state
        set_id(5'd5, 1'b1, 5'd6, 1'b1, 5'd1, 1'b0);
        #1;
        check("reset.rs1", final_rs1, RD1);
        check("reset.rs2", final_rs2, RD2);
        check_ctl("reset", 1'b0, 1'b0, 1'b0);
        idle_id();
        @(negedge clk);
        rst_n = 1'b1;

        //    name          A        B        C        rs1     rs2     rdr e_rs1 e_rs2 cd  st  ff  xf
        addv("ex_fwd",      0,0,     0,0,     5,0,     5,1,    0,0,    0,  W0,  RD2, 1,  0,  0,  0);
        addv("youngest",    0,0,     5,0,     5,0,     5,1,    0,0,    0,  W0,  RD2, 1,  0,  0,  0);
        addv("mem_fwd",     0,0,     5,0,     0,0,     5,1,    0,0,    0,  W1,  RD2, 1,  0,  0,  0);
        addv("wb_fwd",      3,0,     0,0,     0,0,     3,1,    0,0,    0,  W2,  RD2, 1,  0,  0,  0);
        addv("x0_nofwd",    0,0,     0,0,     0,0,     0,1,    0,1,    0,  RD1, RD2, 1,  0,  0,  0);
        addv("load_use",    0,0,     0,0,     7,1,     0,0,    7,1,    0,  RD1, RD2, 0,  1,  0,  1);
        addv("load_mem",    0,0,     7,1,     0,0,     0,0,    7,1,    0,  RD1, W1,  1,  0,  0,  0);
        addv("no_use",      0,0,     0,0,     7,1,     0,0,    7,0,    0,  RD1, RD2, 1,  0,  0,  0);
        addv("redir_lu",    0,0,     0,0,     7,1,     7,1,    0,0,    1,  RD1, RD2, 0,  0,  1,  1);
        addv("rs2_only",    0,0,     0,0,     6,0,     5,1,    6,1,    0,  RD1, W0,  1,  0,  0,  0);
        addv("both_src",    0,0,     9,0,     9,0,     9,1,    9,1,    0,  W0,  W0,  1,  0,  0,  0);
        addv("redir_only",  0,0,     0,0,     0,0,     0,0,    0,0,    1,  RD1, RD2, 1,  0,  1,  1);
        addv("add_over_ld", 0,0,     7,1,     7,0,     7,1,    0,0,    0,  W0,  RD2, 1,  0,  0,  0);

        foreach (vq[i]) begin
            do_reset();
            for (int p = 0; p < 3; p++) push(vq[i].p_rd[p], vq[i].p_ld[p]);
            set_id(vq[i].rs1, vq[i].u1, vq[i].rs2, vq[i].u2, 5'd1, vq[i].redir);
            #1;
            if (vq[i].chk_data) begin
                check({vq[i].name, ".rs1"}, final_rs1, vq[i].e_rs1);
                check({vq[i].name, ".rs2"}, final_rs2, vq[i].e_rs2);
            end
            check_ctl(vq[i].name, vq[i].e_stall, vq[i].e_ifid, vq[i].e_idex);
            idle_id();
        end

        // LW x7 then ADD uses x7: one stall cycle, then forward from MEM.
        do_reset();
        push(5'd7, 1'b1);
        set_id(5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b0);
        #1;
        check_ctl("lu_c1", 1'b1, 1'b0, 1'b1);
        @(posedge clk); #1;
        check_ctl("lu_c2", 1'b0, 1'b0, 1'b0);
        check("lu_c2.rs2", final_rs2, W1);

        // Redirect with load-use: ID instruction (rd x8) must not enter the scoreboard.
        do_reset();
        push(5'd7, 1'b1);
        set_id(5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1);
        #1;
        check_ctl("rdlu_c1", 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        set_id(5'd8, 1'b1, 5'd7, 1'b1, 5'd1, 1'b0);
        #1;
        check("rdlu_c2.bubble", final_rs1, RD1);
        check("rdlu_c2.ld_mem", final_rs2, W1);
        check_ctl("rdlu_c2", 1'b0, 1'b0, 1'b0);

        // Entry shifts out past WB.
        do_reset();
        push(5'd4, 1'b0);
        for (int c = 0; c < 3; c++) push(5'd0, 1'b0);
        set_id(5'd4, 1'b1, 5'd0, 1'b0, 5'd1, 1'b0);
        #1;
        check("dropped.rs1", final_rs1, RD1);

        // Reset mid-stall drops stall immediately.
        do_reset();
        push(5'd7, 1'b1);
        set_id(5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b0);
        #1;
        check("rst_mid.before", {31'd0, stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid.after", {31'd0, stall}, 32'd0);
        check("rst_mid.rs1", final_rs1, RD1);
        rst_n = 1'b1;
        idle_id();

`ifdef HAZ_PERF_CNT_EN
        do_reset();
        check("cnt.reset_stall", stall_cnt, 32'd0);
        check("cnt.reset_flush", flush_cnt, 32'd0);
        for (int n = 0; n < 3; n++) begin
            push(5'd7, 1'b1);
            set_id(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
            @(posedge clk); #1;
            idle_id();
        end
        for (int n = 0; n < 2; n++) begin
            idle_id();
            redirect = 1'b1;
            @(posedge clk); #1;
        end
        idle_id();
        push(5'd7, 1'b1);
        set_id(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        check("cnt.stall_pre", {31'd0, stall}, 32'd1);
        check("cnt.stall_cnt", stall_cnt, 32'd3);
        check("cnt.flush_cnt", flush_cnt, 32'd2);
        rst_n = 1'b0;
        #1;
        check("cnt.stall_post", {31'd0, stall}, 32'd0);
        check("cnt.stall_clr", stall_cnt, 32'd0);
        check("cnt.flush_clr", flush_cnt, 32'd0);
        rst_n = 1'b1;
        idle_id();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
